double_sqrt_drain: RTL and testbench

DOUBLE_SQRT_DRAIN -- requirements
Module: double_sqrt_drain

---
 rtl/double_sqrt_drain_pkg.sv | 34 +++
 rtl/double_sqrt_drain_fifo.sv | 67 ++++++
 rtl/double_sqrt_drain.sv | 102 ++++++++++
 tb/tb_double_sqrt_drain.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/double_sqrt_drain_pkg.sv
// double_sqrt_drain_pkg
// Shared constants for the double_sqrt result drain: the IEEE-754 double
// layout, the result flag indices and a small classifier used to tag each
// result as it enters the drain FIFO.
package double_sqrt_drain_pkg;

  localparam int DOUBLE_W = 64;
  localparam int EXP_W    = 11;
  localparam int MANT_W   = 52;
  localparam int EXP_LSB  = MANT_W;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  // Flag vector layout: {nan, inf, zero}
  localparam int FLAG_W    = 3;
  localparam int FLAG_NAN  = 2;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_ZERO = 0;

  // Sign is ignored: -0 counts as zero, -inf as inf.
  function automatic logic [FLAG_W-1:0] classify(input logic [DOUBLE_W-1:0] d);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    logic [FLAG_W-1:0] f;
    e = d[EXP_LSB +: EXP_W];
    m = d[MANT_W-1:0];
    f = '0;
    f[FLAG_NAN]  = (e == EXP_ALL_ONES) && (m != '0);
    f[FLAG_INF]  = (e == EXP_ALL_ONES) && (m == '0);
    f[FLAG_ZERO] = (e == '0) && (m == '0);
    return f;
  endfunction

endpackage

// File: rtl/double_sqrt_drain_fifo.sv
// drain_fifo
// Result buffer for double_sqrt_drain. A push into a full FIFO without a
// simultaneous pop overwrites the oldest entry (the read pointer advances
// with the write pointer), so the newest DEPTH results are always kept.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write an entry this cycle
//   pop               take the head entry (ignored when empty)
//   head              head entry, zero when empty
//   count             number of stored entries (0..DEPTH)
module drain_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             full;
  logic             drop_oldest;

  assign do_pop      = pop && (count != '0);
  assign full        = (count == FULL_CNT);
  assign drop_oldest = push && full && !do_pop;

  // Pointers wrap modulo DEPTH through natural overflow (DEPTH is 2^AW).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= AW'(wr_ptr + 1'b1);
      if (do_pop || drop_oldest)
        rd_ptr <= AW'(rd_ptr + 1'b1);
      if (push && !do_pop && !full)
        count <= (AW+1)'(count + 1'b1);
      else if (do_pop && !push)
        count <= (AW+1)'(count - 1'b1);
    end
  end

  // NOTE: the storage array has no reset; validity comes from count, and
  // head is forced to zero while empty so nothing stale is ever presented.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/double_sqrt_drain.sv
// double_sqrt_drain
// Collects results from a fixed-latency double_sqrt pipeline into a small
// FIFO. A LATENCY-bit valid shift register mirrors the pipeline so pipe_z is
// captured exactly when an issued operand's result appears. issue_ok limits
// issues so that buffered plus in-flight results never exceed DEPTH; issuing
// anyway sets the sticky overflow flag and the oldest buffered result is lost.
// Optional feature macro: DOUBLE_SQRT_DRAIN_FLAGS_EN adds z_flags
// {nan, inf, zero}, classified at push time and stored with each entry.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   issue_stb     an operand entered double_sqrt this cycle
//   issue_ok      upstream may issue this cycle
//   pipe_z        double_sqrt result bus
//   z, z_stb      FIFO head result and its valid
//   z_ack         consumer takes z when z_stb is high
//   overflow      sticky: an issue was made while issue_ok was low
//   z_flags       (flags build only) classification of z
module double_sqrt_drain
  import double_sqrt_drain_pkg::*;
#(
  parameter int LATENCY = 24,
  parameter int DEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_stb,
  output logic                issue_ok,
  input  logic [DOUBLE_W-1:0] pipe_z,
  output logic [DOUBLE_W-1:0] z,
  output logic                z_stb,
  input  logic                z_ack,
  output logic                overflow
`ifdef DOUBLE_SQRT_DRAIN_FLAGS_EN
  ,
  output logic [FLAG_W-1:0]   z_flags
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(LATENCY + 1);
`ifdef DOUBLE_SQRT_DRAIN_FLAGS_EN
  localparam int EW = DOUBLE_W + FLAG_W;
`else
  localparam int EW = DOUBLE_W;
`endif

  logic [LATENCY-1:0] vld;
  logic               tail;
  logic [IW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic [EW-1:0]      push_data;
  logic [EW-1:0]      head;

  assign tail = vld[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld      <= '0;
      inflight <= '0;
      overflow <= 1'b0;
    end else begin
      vld <= (vld << 1) | LATENCY'(issue_stb);
      // An issue and a retirement in the same cycle cancel out.
      case ({issue_stb, tail})
        2'b10:   inflight <= IW'(inflight + 1'b1);
        2'b01:   inflight <= IW'(inflight - 1'b1);
        default: inflight <= inflight;
      endcase
      if (issue_stb && !issue_ok)
        overflow <= 1'b1;
    end
  end

  // Reserving room for every in-flight result guarantees a push never
  // meets a full FIFO unless upstream ignored issue_ok.
  assign issue_ok = (int'(fifo_count) + int'(inflight)) < DEPTH;

`ifdef DOUBLE_SQRT_DRAIN_FLAGS_EN
  assign push_data = {classify(pipe_z), pipe_z};
  assign z         = head[DOUBLE_W-1:0];
  assign z_flags   = head[DOUBLE_W +: FLAG_W];
`else
  assign push_data = pipe_z;
  assign z         = head;
`endif

  drain_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tail),
    .push_data (push_data),
    .pop       (z_ack),
    .head      (head),
    .count     (fifo_count)
  );

  assign z_stb = (fifo_count != '0);

endmodule

// File: tb/tb_double_sqrt_drain.sv
// tb_double_sqrt_drain
// Scoreboard bench for double_sqrt_drain (LATENCY=24, DEPTH=8). A delay-line
// model stands in for the double_sqrt pipeline; expected results are queued
// at issue time and compared whenever the consumer takes z.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_double_sqrt_drain;

  localparam int LAT = 24;
  localparam int DEP = 8;

  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  f;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_stb;
  logic        issue_ok;
  logic [63:0] pipe_z;
  logic [63:0] z;
  logic        z_stb;
  logic        z_ack;
  logic        overflow;
`ifdef DOUBLE_SQRT_DRAIN_FLAGS_EN
  logic [2:0]  z_flags;
`endif

  logic [63:0] issue_data;
  logic [63:0] pipe_sr [LAT];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  double_sqrt_drain #(
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .issue_stb (issue_stb),
    .issue_ok  (issue_ok),
    .pipe_z    (pipe_z),
    .z         (z),
    .z_stb     (z_stb),
    .z_ack     (z_ack),
    .overflow  (overflow)
`ifdef DOUBLE_SQRT_DRAIN_FLAGS_EN
    ,
    .z_flags   (z_flags)
`endif
  );

  // Pipeline stand-in: an issued operand's value comes out LAT cycles later;
  // idle slots carry garbage that must never be captured.
  always @(posedge clk) begin
    for (int i = LAT-1; i > 0; i--)
      pipe_sr[i] <= pipe_sr[i-1];
    pipe_sr[0] <= issue_stb ? issue_data : {32'hBAD0_BAD0, 32'($urandom)};
  end
  assign pipe_z = pipe_sr[LAT-1];

  function automatic logic [2:0] ref_flags(input logic [63:0] d);
    if (d[62:52] == 11'h7FF)
      return (d[51:0] != 52'd0) ? 3'b100 : 3'b010;
    else if (d[62:0] == 63'd0)
      return 3'b001;
    else
      return 3'b000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, score any transfer, advance to the next falling edge.
  task automatic cycle(input logic stb, input logic [63:0] d, input logic ack);
    exp_t e;
    issue_stb  = stb;
    issue_data = d;
    z_ack      = ack;
    if (z_stb && ack) begin
      if (sb.size() == 0) begin
        check("z_stb_unexpected", 64'(z_stb), 64'd0);
      end else begin
        e = sb.pop_front();
        check("z_order", z, e.d);
`ifdef DOUBLE_SQRT_DRAIN_FLAGS_EN
        check("z_flags_sb", 64'(z_flags), 64'(e.f));
`endif
      end
    end
    if (stb)
      sb.push_back({d, ref_flags(d)});
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && sb.size() != 0; i++)
      cycle(1'b0, 64'd0, 1'b1);
    check(tag, 64'(sb.size()), 64'd0);
    check({tag, "_stb"}, 64'(z_stb), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    issue_stb  = 1'b0;
    issue_data = '0;
    z_ack      = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_z_stb", 64'(z_stb), 64'd0);
    check("rst_z", z, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_issue_ok", 64'(issue_ok), 64'd1);
    rst = 1'b0;

    // First-result latency: issue at cycle 0, z_stb rises at cycle LAT+1.
    cycle(1'b1, 64'h4000_0000_0000_0000, 1'b0);
    repeat (LAT-1) cycle(1'b0, 64'd0, 1'b0);
    check("lat_no_bypass", 64'(z_stb), 64'd0);
    cycle(1'b0, 64'd0, 1'b0);
    check("lat_z_stb", 64'(z_stb), 64'd1);
    check("lat_z", z, 64'h4000_0000_0000_0000);
    cycle(1'b0, 64'd0, 1'b1);
    check("lat_empty", 64'(z_stb), 64'd0);

    // Fill with no consumer: issue_ok falls after DEP issues.
    for (int i = 0; i < DEP; i++) begin
      check("fill_issue_ok", 64'(issue_ok), 64'd1);
      cycle(1'b1, 64'h1000 + 64'(i), 1'b0);
    end
    check("fill_issue_ok_low", 64'(issue_ok), 64'd0);
    repeat (LAT+2) cycle(1'b0, 64'd0, 1'b0);
    check("fill_z_stb", 64'(z_stb), 64'd1);
    check("fill_overflow", 64'(overflow), 64'd0);
    check("fill_still_stalled", 64'(issue_ok), 64'd0);

    // Drain: one pop per cycle in issue order, issue_ok back after first pop.
    for (int i = 0; i < DEP; i++) begin
      check("drain_z_stb", 64'(z_stb), 64'd1);
      cycle(1'b0, 64'd0, 1'b1);
      if (i == 0)
        check("drain_issue_ok", 64'(issue_ok), 64'd1);
    end
    check("drain_empty_stb", 64'(z_stb), 64'd0);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);

    // Streaming with z_ack held: push and pop coincide back to back.
    for (int i = 0; i < 120; i++)
      cycle(issue_ok, {32'h5000_0000, 32'($urandom)}, 1'b1);
    drain("stream_drain");

    // Random consumer, including pops while empty.
    for (int i = 0; i < 200; i++)
      cycle(issue_ok && ($urandom_range(0, 3) != 0),
            {32'h6000_0000, 32'($urandom)}, 1'($urandom_range(0, 1)));
    drain("random_drain");
    check("random_overflow", 64'(overflow), 64'd0);

    // Reset with 3 buffered and 5 in flight.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 64'h7000 + 64'(i), 1'b0);
    repeat (LAT+1) cycle(1'b0, 64'd0, 1'b0);
    check("pre_rst_z_stb", 64'(z_stb), 64'd1);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 64'h7100 + 64'(i), 1'b0);
    repeat (2) cycle(1'b0, 64'd0, 1'b0);
    rst = 1'b1;
    cycle(1'b0, 64'd0, 1'b0);
    rst = 1'b0;
    sb.delete();
    check("mid_rst_z_stb", 64'(z_stb), 64'd0);
    check("mid_rst_z", z, 64'd0);
    check("mid_rst_issue_ok", 64'(issue_ok), 64'd1);
    for (int i = 0; i < LAT+2; i++) begin
      cycle(1'b0, 64'd0, 1'b0);
      check("post_rst_quiet", 64'(z_stb), 64'd0);
    end

    // Overflow: a ninth issue overwrites the oldest entry.
    for (int i = 0; i < DEP; i++)
      cycle(1'b1, 64'h8000 + 64'(i), 1'b0);
    check("ovf_issue_ok", 64'(issue_ok), 64'd0);
    cycle(1'b1, 64'h8FFF, 1'b0);
    void'(sb.pop_front());
    check("ovf_set", 64'(overflow), 64'd1);
    repeat (LAT+2) cycle(1'b0, 64'd0, 1'b0);
    drain("ovf_drain");
    check("ovf_sticky", 64'(overflow), 64'd1);
    rst = 1'b1;
    cycle(1'b0, 64'd0, 1'b0);
    rst = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);

`ifdef DOUBLE_SQRT_DRAIN_FLAGS_EN
    cycle(1'b1, 64'h7FF8_0000_0000_0000, 1'b0);
    cycle(1'b1, 64'h0000_0000_0000_0000, 1'b0);
    cycle(1'b1, 64'hFFF0_0000_0000_0000, 1'b0);
    cycle(1'b1, 64'h3FF0_0000_0000_0000, 1'b0);
    repeat (LAT+2) cycle(1'b0, 64'd0, 1'b0);
    check("flags_nan", 64'(z_flags), 64'(3'b100));
    cycle(1'b0, 64'd0, 1'b1);
    check("flags_zero", 64'(z_flags), 64'(3'b001));
    cycle(1'b0, 64'd0, 1'b1);
    check("flags_inf", 64'(z_flags), 64'(3'b010));
    cycle(1'b0, 64'd0, 1'b1);
    check("flags_normal", 64'(z_flags), 64'(3'b000));
    drain("flags_drain");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
